cv32e40p_irq_arbiter: RTL and testbench

CLIC-style interrupt arbiter sitting directly upstream of the core's interrupt inputs (irq_i / irq_level_i / irq_shv_i / irq_id / irq_ack). It latches per-source pending state, selects the highest-level enabled pending source above a threshold, and presents one registered request with id, level and vectoring mode. The core's acknowledge, carrying the taken id, clears edge-triggered pending state.

---
 rtl/cv32e40p_irq_pkg.sv | 39 +++
 rtl/cv32e40p_irq_prio_tree.sv | 27 ++
 rtl/cv32e40p_irq_arbiter.sv | 108 ++++++++++
 tb/tb_cv32e40p_irq_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_irq_pkg.sv
// Shared types for the CLIC-style interrupt arbiter: per-source config, candidate record, pick helper.
package cv32e40p_irq_pkg;

   // Storage widths of the shared structs; instance widths must not exceed these.
   localparam int unsigned IRQ_ID_W_MAX    = 8;
   localparam int unsigned IRQ_LEVEL_W_MAX = 16;

   // Bit positions in cfg_wdata, relative to LEVEL_W (level occupies [LEVEL_W-1:0]).
   localparam int unsigned CFG_SHV_OFS  = 0;
   localparam int unsigned CFG_EDGE_OFS = 1;
   localparam int unsigned CFG_IE_OFS   = 2;

   typedef struct packed {
      logic                       ie;
      logic                       edge_trig;
      logic                       shv;
      logic [IRQ_LEVEL_W_MAX-1:0] level;
   } irq_cfg_t;

   typedef struct packed {
      logic                       valid;
      logic [IRQ_ID_W_MAX-1:0]    id;
      logic [IRQ_LEVEL_W_MAX-1:0] level;
      logic                       shv;
   } irq_sel_t;

   // Pick the better of two candidates; 'hi' always carries the higher ids, so it wins ties.
   function automatic irq_sel_t irq_sel_pick(irq_sel_t lo, irq_sel_t hi);
      irq_sel_t res;
      res = lo;
      if (!lo.valid) begin
         res = hi;
      end else if (hi.valid && (hi.level >= lo.level)) begin
         res = hi;
      end
      return res;
   endfunction

endpackage

// File: rtl/cv32e40p_irq_prio_tree.sv
// Combinational balanced max-tree over candidates; highest level wins, higher id on ties.
module cv32e40p_irq_prio_tree
   import cv32e40p_irq_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  irq_sel_t [N-1:0] sel_i,
   output irq_sel_t         sel_o
);

   // Heap layout: leaves at [N-1 .. 2N-2] in id order, node k has children 2k+1 (low) and 2k+2 (high).
   irq_sel_t node [2*N-1];

   // Reduce leaves pairwise towards the root.
   always_comb begin
      node = '{default: '0};
      for (int i = 0; i < int'(N); i++) begin
         node[int'(N) - 1 + i] = sel_i[i];
      end
      for (int k = int'(N) - 2; k >= 0; k--) begin
         node[k] = irq_sel_pick(node[2*k + 1], node[2*k + 2]);
      end
   end

   assign sel_o = node[0];

endmodule

// File: rtl/cv32e40p_irq_arbiter.sv
// Interrupt arbiter: per-source pending/config state, priority selection and registered request to the core.
module cv32e40p_irq_arbiter
   import cv32e40p_irq_pkg::*;
#(
   parameter  int unsigned NUM_SRC = 32,
   parameter  int unsigned LEVEL_W = 8,
   localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               cfg_we_i,
   input  logic [ID_W-1:0]    cfg_idx_i,
   input  logic [LEVEL_W+2:0] cfg_wdata_i,
   input  logic [LEVEL_W-1:0] thresh_i,
   output logic               irq_valid_o,
   output logic [ID_W-1:0]    irq_id_o,
   output logic [LEVEL_W-1:0] irq_level_o,
   output logic               irq_shv_o,
   input  logic               irq_ack_i,
   input  logic [ID_W-1:0]    irq_ack_id_i,
   output logic [NUM_SRC-1:0] pend_o
);

   irq_cfg_t                  cfg_q [NUM_SRC];
   irq_cfg_t                  cfg_wr;
   logic [NUM_SRC-1:0]        src_q;
   logic [NUM_SRC-1:0]        pend_edge_q;
   logic [NUM_SRC-1:0]        pend_edge_d;
   logic [NUM_SRC-1:0]        pend;
   irq_sel_t [NUM_SRC-1:0]    cand;
   irq_sel_t                  win;

   // Unpack the config write word.
   always_comb begin
      cfg_wr           = '0;
      cfg_wr.ie        = cfg_wdata_i[LEVEL_W + CFG_IE_OFS];
      cfg_wr.edge_trig = cfg_wdata_i[LEVEL_W + CFG_EDGE_OFS];
      cfg_wr.shv       = cfg_wdata_i[LEVEL_W + CFG_SHV_OFS];
      cfg_wr.level     = IRQ_LEVEL_W_MAX'(cfg_wdata_i[LEVEL_W-1:0]);
   end

   // Pending update and eligibility; a new rising edge beats a same-cycle ack, and the acked id sits out one arbitration.
   always_comb begin
      pend_edge_d = '0;
      pend        = '0;
      cand        = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         logic               rise;
         logic               ack_hit;
         logic [LEVEL_W-1:0] lvl;
         rise    = src_i[i] & ~src_q[i];
         ack_hit = irq_ack_i && (irq_ack_id_i == ID_W'(i));
         lvl     = LEVEL_W'(cfg_q[i].level);

         pend_edge_d[i] = cfg_q[i].edge_trig & (rise | (pend_edge_q[i] & ~ack_hit));
         if (cfg_we_i && (cfg_idx_i == ID_W'(i)) && !cfg_wr.edge_trig) begin
            pend_edge_d[i] = 1'b0;
         end

         pend[i] = cfg_q[i].edge_trig ? pend_edge_q[i] : src_i[i];

         cand[i].valid = pend[i] & cfg_q[i].ie & (lvl != '0) & (lvl > thresh_i) & ~ack_hit;
         cand[i].id    = IRQ_ID_W_MAX'(i);
         cand[i].level = IRQ_LEVEL_W_MAX'(lvl);
         cand[i].shv   = cfg_q[i].shv;
      end
   end

   cv32e40p_irq_prio_tree #(
      .N (NUM_SRC)
   ) u_prio_tree (
      .sel_i (cand),
      .sel_o (win)
   );

   assign pend_o = pend;

   // Config, edge-detect history, pending bits and the registered request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NUM_SRC); i++) begin
            cfg_q[i] <= '0;
         end
         src_q       <= '0;
         pend_edge_q <= '0;
         irq_valid_o <= 1'b0;
         irq_id_o    <= '0;
         irq_level_o <= '0;
         irq_shv_o   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (cfg_we_i && (cfg_idx_i == ID_W'(i))) begin
               cfg_q[i] <= cfg_wr;
            end
         end
         src_q       <= src_i;
         pend_edge_q <= pend_edge_d;
         irq_valid_o <= win.valid;
         if (win.valid) begin
            irq_id_o    <= ID_W'(win.id);
            irq_level_o <= LEVEL_W'(win.level);
            irq_shv_o   <= win.shv;
         end
      end
   end

endmodule

// File: tb/tb_cv32e40p_irq_arbiter.sv
// Directed bench for cv32e40p_irq_arbiter with hand-computed expectations.
module tb_cv32e40p_irq_arbiter;

   localparam int unsigned NUM_SRC = 32;
   localparam int unsigned LEVEL_W = 8;
   localparam int unsigned ID_W    = 5;

   logic               clk;
   logic               rst;
   logic [NUM_SRC-1:0] src;
   logic               cfg_we;
   logic [ID_W-1:0]    cfg_idx;
   logic [LEVEL_W+2:0] cfg_wdata;
   logic [LEVEL_W-1:0] thresh;
   logic               irq_valid;
   logic [ID_W-1:0]    irq_id;
   logic [LEVEL_W-1:0] irq_level;
   logic               irq_shv;
   logic               ack;
   logic [ID_W-1:0]    ack_id;
   logic [NUM_SRC-1:0] pend;

   int n_chk  = 0;
   int n_fail = 0;

   cv32e40p_irq_arbiter #(
      .NUM_SRC (NUM_SRC),
      .LEVEL_W (LEVEL_W)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .src_i        (src),
      .cfg_we_i     (cfg_we),
      .cfg_idx_i    (cfg_idx),
      .cfg_wdata_i  (cfg_wdata),
      .thresh_i     (thresh),
      .irq_valid_o  (irq_valid),
      .irq_id_o     (irq_id),
      .irq_level_o  (irq_level),
      .irq_shv_o    (irq_shv),
      .irq_ack_i    (ack),
      .irq_ack_id_i (ack_id),
      .pend_o       (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input int idx, input logic ie, input logic edg, input logic shv, input logic [LEVEL_W-1:0] lvl);
      cfg_we    = 1'b1;
      cfg_idx   = ID_W'(idx);
      cfg_wdata = {ie, edg, shv, lvl};
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic do_ack(input int id);
      ack    = 1'b1;
      ack_id = ID_W'(id);
      step();
      ack    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; src = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
      thresh = '0; ack = 1'b0; ack_id = '0;
      step(); step();
      chk("rst_valid", 32'(irq_valid), 32'd0);
      chk("rst_id",    32'(irq_id),    32'd0);
      chk("rst_level", 32'(irq_level), 32'd0);
      chk("rst_shv",   32'(irq_shv),   32'd0);
      chk("rst_pend",  pend,           32'd0);
      rst = 1'b0;
      step();

      // 1: edge source 5, level 3
      cfg(5, 1'b1, 1'b1, 1'b0, 8'd3);
      src[5] = 1'b1;
      step();
      src[5] = 1'b0;
      chk("t1_pend5",      32'(pend[5]),   32'd1);
      chk("t1_valid_pre",  32'(irq_valid), 32'd0);
      step();
      chk("t1_valid", 32'(irq_valid), 32'd1);
      chk("t1_id",    32'(irq_id),    32'd5);
      chk("t1_level", 32'(irq_level), 32'd3);
      chk("t1_shv",   32'(irq_shv),   32'd0);
      do_ack(5);
      chk("t1_valid_ack", 32'(irq_valid), 32'd0);
      chk("t1_pend5_ack", 32'(pend[5]),   32'd0);
      step();
      chk("t1_valid_idle", 32'(irq_valid), 32'd0);

      // 2: equal level tie -> higher id
      cfg(3, 1'b1, 1'b1, 1'b1, 8'd4);
      cfg(9, 1'b1, 1'b1, 1'b0, 8'd4);
      src[3] = 1'b1; src[9] = 1'b1;
      step();
      src[3] = 1'b0; src[9] = 1'b0;
      step();
      chk("t2_valid", 32'(irq_valid), 32'd1);
      chk("t2_id9",   32'(irq_id),    32'd9);
      chk("t2_level", 32'(irq_level), 32'd4);
      do_ack(9);
      chk("t2_valid3", 32'(irq_valid), 32'd1);
      chk("t2_id3",    32'(irq_id),    32'd3);
      chk("t2_shv3",   32'(irq_shv),   32'd1);
      chk("t2_pend",   pend,           32'h0000_0008);

      // 3: threshold must be strictly exceeded
      thresh = 8'd4;
      step();
      chk("t3_valid_th4", 32'(irq_valid), 32'd0);
      chk("t3_id_hold",   32'(irq_id),    32'd3);
      thresh = 8'd3;
      step();
      chk("t3_valid_th3", 32'(irq_valid), 32'd1);
      chk("t3_id_th3",    32'(irq_id),    32'd3);
      do_ack(3);
      chk("t3_valid_ack", 32'(irq_valid), 32'd0);
      do_ack(12);
      chk("t3_stray_pend",  pend,           32'd0);
      chk("t3_stray_valid", 32'(irq_valid), 32'd0);

      // 4: level-triggered source 7
      thresh = 8'd0;
      cfg(7, 1'b1, 1'b0, 1'b1, 8'd5);
      src[7] = 1'b1;
      step();
      chk("t4_valid", 32'(irq_valid), 32'd1);
      chk("t4_id",    32'(irq_id),    32'd7);
      chk("t4_level", 32'(irq_level), 32'd5);
      do_ack(7);
      chk("t4_valid_masked", 32'(irq_valid), 32'd0);
      chk("t4_pend7",        32'(pend[7]),   32'd1);
      step();
      chk("t4_valid_re", 32'(irq_valid), 32'd1);
      chk("t4_id_re",    32'(irq_id),    32'd7);
      src[7] = 1'b0;
      step();
      chk("t4_valid_drop", 32'(irq_valid), 32'd0);
      chk("t4_pend7_drop", 32'(pend[7]),   32'd0);

      // 5: ack and new rising edge in the same cycle
      cfg(2, 1'b1, 1'b1, 1'b0, 8'd6);
      src[2] = 1'b1;
      step();
      src[2] = 1'b0;
      step();
      chk("t5_valid", 32'(irq_valid), 32'd1);
      chk("t5_id",    32'(irq_id),    32'd2);
      src[2] = 1'b1;
      do_ack(2);
      src[2] = 1'b0;
      chk("t5_pend2",        32'(pend[2]),   32'd1);
      chk("t5_valid_masked", 32'(irq_valid), 32'd0);
      step();
      chk("t5_valid_re", 32'(irq_valid), 32'd1);
      chk("t5_id_re",    32'(irq_id),    32'd2);
      chk("t5_level_re", 32'(irq_level), 32'd6);
      do_ack(2);
      chk("t5_pend_clr", pend, 32'd0);

      // 6: asynchronous reset in the middle of a request
      src[5] = 1'b1;
      step();
      src[5] = 1'b0;
      step();
      chk("t6_valid_pre", 32'(irq_valid), 32'd1);
      chk("t6_id_pre",    32'(irq_id),    32'd5);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid_async", 32'(irq_valid), 32'd0);
      chk("t6_id_async",    32'(irq_id),    32'd0);
      chk("t6_level_async", 32'(irq_level), 32'd0);
      chk("t6_pend_async",  pend,           32'd0);
      step();
      rst = 1'b0;
      step();
      src[5] = 1'b1; src[2] = 1'b1;
      step();
      src[5] = 1'b0; src[2] = 1'b0;
      step();
      chk("t6_valid_post", 32'(irq_valid), 32'd0);
      chk("t6_pend_post",  pend,           32'd0);
      step();
      chk("t6_valid_post2", 32'(irq_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
